// File: rtl/range_op_pkg.sv
// range_op_pkg: opcodes, FSM states and widths shared by range_op_seq and sub_step.
package range_op_pkg;
  localparam int OPW  = 8;
  localparam int RESW = 16;
  localparam logic [1:0] OP_MOD = 2'b00;
  localparam logic [1:0] OP_SUM = 2'b01;
  localparam logic [1:0] OP_AVG = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;
  typedef enum logic [2:0] {IDLE, MOD, SUM, DIV, DONE} state_t;
endpackage

// File: rtl/range_op_seq_sub_step.sv
// sub_step: one compare-and-subtract step shared by the MOD and DIV loops.
module sub_step
  import range_op_pkg::*;
(
  input  logic [RESW-1:0] a,
  input  logic [RESW-1:0] b,
  output logic            ge,
  output logic [RESW-1:0] diff
);
  assign ge   = a >= b;
  assign diff = a - b;
endmodule

// File: rtl/range_op_seq.sv
// range_op_seq: multi-cycle MOD / range SUM / range AVG sequencer.
// Optional abort input enabled by defining RANGE_OP_SEQ_ABORT_EN.
module range_op_seq
  import range_op_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [OPW-1:0]  op0,
  input  logic [OPW-1:0]  op1,
  input  logic [1:0]      sel,
`ifdef RANGE_OP_SEQ_ABORT_EN
  input  logic            abort,
`endif
  output logic            busy,
  output logic            done,
  output logic [RESW-1:0] res,
  output logic            err
);
  state_t state, state_n;
  logic [OPW-1:0]  opa, opb;
  logic [1:0]      sel_q;
  logic [RESW-1:0] rem, acc, q;
  logic [OPW:0]    i, cnt;
  logic            ge, sum_go, err_in, stop;
  logic [RESW-1:0] diff, dv, fin_res;

  sub_step u_step (.a(rem), .b(dv), .ge(ge), .diff(diff));

`ifdef RANGE_OP_SEQ_ABORT_EN
  assign stop = abort;
`else
  assign stop = 1'b0;
`endif

  always_comb begin
    dv      = state == DIV ? {7'd0, cnt} : {8'd0, opb};
    sum_go  = i <= {1'b0, opb};
    err_in  = sel == OP_RSV || (sel == OP_MOD && op1 == '0) || (sel == OP_AVG && op0 > op1);
    fin_res = state == MOD ? rem : state == SUM ? acc : state == DIV ? q : '0;
    state_n = state;
    case (state)
      IDLE: state_n = !start ? IDLE : err_in ? DONE : sel == OP_MOD ? MOD : SUM;
      MOD:  state_n = stop ? IDLE : ge ? MOD : DONE;
      SUM:  state_n = stop ? IDLE : sum_go ? SUM : sel_q == OP_AVG ? DIV : DONE;
      DIV:  state_n = stop ? IDLE : ge ? DIV : DONE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = state != IDLE;
  assign done = state == DONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa <= '0; opb <= '0; sel_q <= '0;
      rem <= '0; acc <= '0; q <= '0; i <= '0; cnt <= '0;
      res <= '0; err <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        opa   <= op0;
        opb   <= op1;
        sel_q <= sel;
        rem   <= {8'd0, op0};
        i     <= {1'b0, op0};
        acc   <= '0;
        q     <= '0;
      end
      if (state == MOD && ge) rem <= diff;
      if (state == SUM && sum_go) begin
        acc <= acc + {7'd0, i};
        i   <= i + 9'd1;
      end
      // on loop exit i == op1+1, so i - op0 is the element count
      if (state == SUM && !sum_go) begin
        rem <= acc;
        cnt <= i - {1'b0, opa};
      end
      if (state == DIV && ge) begin
        rem <= diff;
        q   <= q + 16'd1;
      end
      // entering DONE from IDLE is always an error case
      if (state_n == DONE && state != DONE) begin
        res <= fin_res;
        err <= state == IDLE;
      end
    end
  end
endmodule

// File: tb/tb_range_op_seq.sv
// tb_range_op_seq: directed self-checking bench for range_op_seq (abort tests with RANGE_OP_SEQ_ABORT_EN).
module tb_range_op_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0] op0 = '0, op1 = '0;
  logic [1:0] sel = '0;
  logic busy, done, err;
  logic [15:0] res;
`ifdef RANGE_OP_SEQ_ABORT_EN
  logic abort = 1'b0;
`endif
  int checks = 0, errors = 0;

  range_op_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op0(op0), .op1(op1), .sel(sel),
`ifdef RANGE_OP_SEQ_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .res(res), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic kick(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start = 1'b1; sel = s; op0 = a; op1 = b;
    @(posedge clk);
    #1 start = 1'b0; op0 = ~a; op1 = ~b; sel = ~s;
  endtask

  task automatic run(input string tag, input logic [1:0] s, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] er, input logic ee, input int lat);
    int n;
    n = 0;
    kick(s, a, b);
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 500);
    check({tag, " latency"}, n, lat);
    check({tag, " res"}, res, er);
    check({tag, " err"}, err, ee);
    @(negedge clk);
    check({tag, " idle"}, {busy, done}, 2'b00);
    check({tag, " hold"}, res, er);
  endtask

  initial begin
    int pulses;
    #12;
    check("reset outputs", {busy, done, err, res}, 0);
    rst_n = 1'b1;
    run("mod 200/7", 2'b00, 200, 7, 4, 0, 30);
    run("mod 13/13", 2'b00, 13, 13, 0, 0, 3);
    run("mod 5/9", 2'b00, 5, 9, 5, 0, 2);
    run("mod /0", 2'b00, 9, 0, 0, 1, 1);
    run("sum 10..20", 2'b01, 10, 20, 165, 0, 13);
    run("sum 0..255", 2'b01, 0, 255, 32640, 0, 258);
    run("sum 7..7", 2'b01, 7, 7, 7, 0, 3);
    run("sum empty", 2'b01, 9, 3, 0, 0, 2);
    run("avg 1..4", 2'b10, 1, 4, 2, 0, 9);
    run("avg 5..3", 2'b10, 5, 3, 0, 1, 1);
    run("avg 6..6", 2'b10, 6, 6, 6, 0, 10);
    run("avg 0..255", 2'b10, 0, 255, 127, 0, 386);
    run("rsv", 2'b11, 1, 2, 0, 1, 1);
    // second start while busy must be ignored
    kick(2'b00, 200, 7);
    pulses = 0;
    repeat (4) @(negedge clk);
    start = 1'b1; sel = 2'b01; op0 = 1; op1 = 2;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check("busy start ignored pulses", pulses, 1);
    check("busy start ignored res", res, 4);
    // start held high: a new op every other cycle, never from DONE
    @(negedge clk);
    start = 1'b1; sel = 2'b11;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    start = 1'b0;
    check("held start pulses", pulses, 3);
    run("sum 1..2", 2'b01, 1, 2, 3, 0, 4);
    // reset mid-SUM
    kick(2'b01, 0, 255);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1 check("mid reset outputs", {busy, done, err, res}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    check("no activity after reset", pulses, 0);
    run("sum 1..3", 2'b01, 1, 3, 6, 0, 5);
`ifdef RANGE_OP_SEQ_ABORT_EN
    kick(2'b01, 0, 255);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort idle", {busy, done}, 2'b00);
    check("abort res kept", res, 6);
    pulses = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort no done", pulses, 0);
    run("after abort", 2'b10, 1, 4, 2, 0, 9);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/range_op_seq.md
RANGE_OP_SEQ -- requirements
Module: range_op_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 start  in  1  operation request; sampled only in IDLE.
REQ-003 op0  in  8  first operand (dividend / range low bound), unsigned.
REQ-004 op1  in  8  second operand (divisor / range high bound), unsigned.
REQ-005 sel  in  2  operation: 00 MOD, 01 SUM, 10 AVG, 11 reserved.
REQ-006 busy  out  1  high in every state except IDLE.
REQ-007 done  out  1  one-cycle pulse; res and err are valid in that cycle.
REQ-008 res  out  16  result, unsigned; held from done until the next accepted start.
REQ-009 err  out  1  error flag; updated with done and held with res.

Function
REQ-010 The FSM SHALL have the states IDLE, MOD, SUM, DIV and DONE; DONE lasts one cycle, asserts done, then returns to IDLE.
REQ-011 At the edge where start=1 in IDLE (edge E0), the block SHALL latch op0, op1 and sel; while busy, start and operand changes SHALL be ignored.
REQ-012 MOD: rem=op0; each MOD cycle with rem>=op1 does rem-=op1; the first cycle with rem<op1 goes to DONE; res={8'd0,rem}; done at edge E0+floor(op0/op1)+2.
REQ-013 SUM: i (9-bit) starts at op0 and acc (16-bit) at 0; each SUM cycle with i<=op1 does acc+=i, i++; the first cycle with i>op1 goes to DONE; res=acc; done at edge E0+N+2, N=op1-op0+1 (N=0 when op0>op1, res=0, err=0).
REQ-014 The 9-bit iterator SHALL guarantee termination at op1=255; the 16-bit acc SHALL never overflow (maximum 32640).
REQ-015 AVG: the SUM phase runs as in REQ-013, then DIV divides acc by cnt=op1-op0+1 using repeated subtraction (one subtraction per cycle plus one terminating cycle); res=floor(sum/cnt); done at edge E0+cnt+floor(sum/cnt)+3.
REQ-016 Error cases (MOD with op1=0, AVG with op0>op1, sel=11) SHALL go IDLE->DONE; done at edge E0+1 with res=0, err=1.
REQ-017 Successful operations SHALL clear err in the done cycle.
REQ-018 start held high SHALL begin a new operation on the edge after DONE (IDLE sampling), never in DONE itself.

Reset
REQ-019 While rst_n=0, the block SHALL force state=IDLE and busy=0, done=0, res=0, err=0, and clear all internal registers.
REQ-020 A reset during an operation SHALL abandon it with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Configuration
REQ-021 With RANGE_OP_SEQ_ABORT_EN defined, the block SHALL add an input abort (1 bit); abort=1 in any busy state except DONE SHALL return the FSM to IDLE on the next edge with no done pulse and res/err unchanged.
REQ-022 Without RANGE_OP_SEQ_ABORT_EN, the abort port SHALL NOT exist and operations always run to DONE.

Structure
REQ-023 A shared package range_op_pkg SHALL hold the sel opcode constants (OP_MOD, OP_SUM, OP_AVG, OP_RSV), the FSM state encoding, and the widths OPW=8 and RESW=16.
REQ-024 The repeated-subtraction step (compare and subtract, used by MOD and DIV) SHALL be a sub-module sub_step; the FSM and counters SHALL remain in range_op_seq.

Verification
REQ-025 MOD op0=200, op1=7 -> res=4, err=0, done at E0+30.
REQ-026 SUM op0=10, op1=20 -> res=165 at E0+13; SUM op0=0, op1=255 -> res=32640 at E0+258 (no hang).
REQ-027 AVG op0=1, op1=4 -> res=2, err=0 at E0+9; AVG op0=5, op1=3 -> res=0, err=1 at E0+1.
REQ-028 MOD op1=0 and sel=11 -> err=1, res=0, done at E0+1; a second start pulsed while busy SHALL be ignored, giving exactly one done.
REQ-029 rst_n low mid-SUM -> no done, all outputs 0; next SUM 1..3 -> res=6.
REQ-030 With RANGE_OP_SEQ_ABORT_EN defined: abort during SUM 0..255 -> IDLE next edge, no done, prior res retained.
